sim_video_capture: RTL

- Parametrised video back-end for the verilator harness and MiSTer top; replaces the ad-hoc 1bpp-to-8bpp replication done at top level.
- Takes an N-bit pixel index plus blank/sync from the core and registers them.
- Maps each pixel to 8-bit RGB through a gray-expansion or fixed palette mode.
- Tracks beam position and measures frame geometry, and emits per-frame strobes the C++ harness uses to blit and detect resolution changes.

---
 rtl/sim_video_pkg.sv | 30 +++
 rtl/sim_video_capture_if.sv | 51 +++++
 rtl/sim_video_geom.sv | 121 ++++++++++++
 rtl/sim_video_capture.sv | 109 ++++++++++
 4 files changed

// File: rtl/sim_video_pkg.sv
// Shared types and constants for the simulation video capture path:
// frame state encoding, the fixed 16-colour palette and the gray expander.
package sim_video_pkg;

  // Frame tracking state: waiting in vertical blank, or inside the active area.
  typedef enum logic {
    VBL    = 1'b0,
    ACTIVE = 1'b1
  } frame_state_e;

  // CGA-ordered palette, {R, G, B} with 8 bits per channel.
  localparam logic [23:0] CGA_PALETTE [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

  // Replicate a bpp-wide index (held in the low bits of idx) MSB-first
  // until 8 bits are filled, so full-scale indices map to 0xFF.
  function automatic logic [7:0] gray_expand(input logic [3:0] idx, input int bpp);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[3'(7 - i)] = idx[2'(bpp - 1 - (i % bpp))];
    end
    return r;
  endfunction

endpackage

// File: rtl/sim_video_capture_if.sv
// Bundle between a video core and the capture back-end.
// There is no backpressure: ce_pix qualifies every input sample, and every
// output changes only in response to an enabled sample (pulses excepted).
interface sim_video_capture_if #(
  parameter int BPP = 1,
  parameter int XW  = 11,
  parameter int YW  = 10
);
  // core side
  logic           ce_pix;
  logic [BPP-1:0] pix_in;
  logic           hblank;
  logic           vblank;
  logic           hsync;
  logic           vsync;

  // capture side
  logic [7:0]     VGA_R;
  logic [7:0]     VGA_G;
  logic [7:0]     VGA_B;
  logic           VGA_HB;
  logic           VGA_VB;
  logic           VGA_HS;
  logic           VGA_VS;
  logic           pix_valid;
  logic [XW-1:0]  pix_x;
  logic [YW-1:0]  pix_y;
  logic           frame_start;
  logic           frame_done;
  logic [XW-1:0]  line_width;
  logic [YW-1:0]  frame_height;
  logic [15:0]    frame_count;
  logic           geom_stable;

  // Video core / harness driving pixels
  modport master (
    output ce_pix, pix_in, hblank, vblank, hsync, vsync,
    input  VGA_R, VGA_G, VGA_B, VGA_HB, VGA_VB, VGA_HS, VGA_VS,
    input  pix_valid, pix_x, pix_y, frame_start, frame_done,
    input  line_width, frame_height, frame_count, geom_stable
  );

  // Capture back-end
  modport slave (
    input  ce_pix, pix_in, hblank, vblank, hsync, vsync,
    output VGA_R, VGA_G, VGA_B, VGA_HB, VGA_VB, VGA_HS, VGA_VS,
    output pix_valid, pix_x, pix_y, frame_start, frame_done,
    output line_width, frame_height, frame_count, geom_stable
  );

endinterface

// File: rtl/sim_video_geom.sv
// Beam position tracking and frame geometry measurement.
// x counts active pixels in the current line, y counts completed non-empty
// lines in the current frame. Both saturate. At each frame end the measured
// geometry is compared with the previous frame to drive geom_stable.
module sim_video_geom
  import sim_video_pkg::*;
#(
  parameter int XW = 11,
  parameter int YW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          hblank,
  input  logic          vblank,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [XW-1:0] line_width,
  output logic [YW-1:0] frame_height,
  output logic [15:0]   frame_count,
  output logic          geom_stable,
  output frame_state_e  state,
  output logic          vb_rise
);

  localparam logic [XW-1:0] X_MAX = '1;
  localparam logic [YW-1:0] Y_MAX = '1;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [XW-1:0] ref_w;
  logic          uniform;
  logic [XW-1:0] prev_w;
  logic [YW-1:0] prev_h;
  logic          have_prev;
  logic          hb_q;
  logic          vb_q;

  logic          active;
  logic          hb_rise;
  logic          close_line;
  logic          first_line;
  logic          frame_end;
  logic [XW-1:0] x_inc;
  logic [YW-1:0] y_inc;
  logic [YW-1:0] y_closed;
  logic [XW-1:0] w_closed;
  logic          uni_closed;

  // Edge detection and the values a line/frame close would commit.
  // A line closes on hblank rising inside the active area, or on vblank
  // rising when the last line never saw its hblank edge; empty lines never
  // close. w_closed/uni_closed/y_closed already include such a closing line
  // so frame end sees the complete frame in the same cycle.
  always_comb begin
    active     = ~hblank & ~vblank;
    hb_rise    = hblank & ~hb_q & ~vblank;
    vb_rise    = vblank & ~vb_q;
    close_line = (x != '0) & (hb_rise | vb_rise);
    first_line = (y == '0);
    frame_end  = ce & vb_rise & (state == ACTIVE);
    x_inc      = (x == X_MAX) ? x : x + 1'b1;
    y_inc      = (y == Y_MAX) ? y : y + 1'b1;
    y_closed   = close_line ? y_inc : y;
    w_closed   = (close_line & first_line) ? x : ref_w;
    uni_closed = close_line ? (first_line | (uniform & (x == ref_w))) : uniform;
  end

  // Frame FSM, beam counters and geometry latches; everything advances on ce only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= VBL;
      x            <= '0;
      y            <= '0;
      ref_w        <= '0;
      uniform      <= 1'b0;
      prev_w       <= '0;
      prev_h       <= '0;
      have_prev    <= 1'b0;
      hb_q         <= 1'b1;
      vb_q         <= 1'b1;
      pix_x        <= '0;
      pix_y        <= '0;
      line_width   <= '0;
      frame_height <= '0;
      frame_count  <= '0;
      geom_stable  <= 1'b0;
    end else if (ce) begin
      hb_q <= hblank;
      vb_q <= vblank;
      if (active) begin
        pix_x <= x;
        x     <= x_inc;
        if (state == VBL) begin
          state <= ACTIVE;
          y     <= '0;
          pix_y <= '0;
        end else begin
          pix_y <= y;
        end
      end else if (close_line) begin
        line_width <= x;
        ref_w      <= w_closed;
        uniform    <= uni_closed;
        y          <= y_inc;
        x          <= '0;
      end
      if (frame_end) begin
        state        <= VBL;
        frame_height <= y_closed;
        frame_count  <= frame_count + 1'b1;
        geom_stable  <= uni_closed & have_prev &
                        (w_closed == prev_w) & (y_closed == prev_h);
        prev_w       <= w_closed;
        prev_h       <= y_closed;
        have_prev    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sim_video_capture.sv
// Video back-end for the simulation harness: registers the core's pixel
// index and timing, maps the index to 8-bit RGB, and reports beam position,
// frame geometry and per-frame strobes. All outputs lag the inputs by one
// enabled pixel.
module sim_video_capture
  import sim_video_pkg::*;
#(
  parameter int BPP      = 1,
  parameter int PAL_MODE = 0,
  parameter int XW       = 11,
  parameter int YW       = 10
) (
  input logic                clk_48,
  input logic                reset,
  sim_video_capture_if.slave vid
);

  logic [3:0]   idx;
  logic         active;
  logic [23:0]  rgb;
  frame_state_e state;
  logic         vb_rise;

  logic [7:0]   r_q;
  logic [7:0]   g_q;
  logic [7:0]   b_q;
  logic         hb_q;
  logic         vb_q;
  logic         hs_q;
  logic         vs_q;
  logic         valid_q;
  logic         start_q;
  logic         done_q;

  // Colour map: the index is zero-extended to 4 bits; blanked pixels are black.
  always_comb begin
    idx    = 4'(vid.pix_in);
    active = ~vid.hblank & ~vid.vblank;
    rgb    = '0;
    if (active) begin
      if (PAL_MODE == 1) begin
        rgb = CGA_PALETTE[idx];
      end else begin
        rgb = {3{gray_expand(idx, BPP)}};
      end
    end
  end

  sim_video_geom #(
    .XW(XW),
    .YW(YW)
  ) u_geom (
    .clk          (clk_48),
    .rst          (reset),
    .ce           (vid.ce_pix),
    .hblank       (vid.hblank),
    .vblank       (vid.vblank),
    .pix_x        (vid.pix_x),
    .pix_y        (vid.pix_y),
    .line_width   (vid.line_width),
    .frame_height (vid.frame_height),
    .frame_count  (vid.frame_count),
    .geom_stable  (vid.geom_stable),
    .state        (state),
    .vb_rise      (vb_rise)
  );

  // Colour/timing delay registers (hold between enables) and the pulse
  // outputs, which are recomputed every clock so they last one cycle.
  always_ff @(posedge clk_48) begin
    if (reset) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hb_q    <= 1'b0;
      vb_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= vid.ce_pix & active;
      start_q <= vid.ce_pix & active & (state == VBL);
      done_q  <= vid.ce_pix & vb_rise & (state == ACTIVE);
      if (vid.ce_pix) begin
        r_q  <= rgb[23:16];
        g_q  <= rgb[15:8];
        b_q  <= rgb[7:0];
        hb_q <= vid.hblank;
        vb_q <= vid.vblank;
        hs_q <= vid.hsync;
        vs_q <= vid.vsync;
      end
    end
  end

  assign vid.VGA_R       = r_q;
  assign vid.VGA_G       = g_q;
  assign vid.VGA_B       = b_q;
  assign vid.VGA_HB      = hb_q;
  assign vid.VGA_VB      = vb_q;
  assign vid.VGA_HS      = hs_q;
  assign vid.VGA_VS      = vs_q;
  assign vid.pix_valid   = valid_q;
  assign vid.frame_start = start_q;
  assign vid.frame_done  = done_q;

endmodule
